mem_access_unit: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit. Converts an EX/MEM load or store into a
// req/gnt/rvalid data-memory transaction and stalls the pipeline until it
// completes. Load data is aligned, extended and registered for MEM/WB.
//
// Ports
//   CLK, rst                 clock, synchronous active-high reset
//   mem_rd_en, mem_wr_en     EX/MEM load / store request
//   funct3, addr, store_data EX/MEM access size/sign, byte address, rs2 value
//   dmem_req/we/be/addr/wdata  registered bus request outputs
//   dmem_gnt, dmem_rvalid, dmem_rdata  bus handshake and read data
//   load_data                registered extended load result
//   mem_stall                freeze upstream pipeline registers
//   misalign_exc             misaligned access in IDLE (no bus traffic)
//   bus_err                  one-cycle pulse after a transaction timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic            mem_rd_en,
   input  logic            mem_wr_en,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] load_data,
   output logic            mem_stall,
   output logic            misalign_exc,
   output logic            bus_err
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } state_t;

   // Access size: 0 = byte, 1 = half, 2 = word (reserved encodings act as word).
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: size_of = 2'd0;
         3'b001, 3'b101: size_of = 2'd1;
         default:        size_of = 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'd0:    be_of = 4'b0001 << off;
         2'd1:    be_of = off[1] ? 4'b1100 : 4'b0011;
         default: be_of = 4'b1111;
      endcase
   endfunction

   // Store data is replicated so the selected lanes carry it whatever the offset.
   function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] sd);
      case (sz)
         2'd0:    wdata_of = {4{sd[7:0]}};
         2'd1:    wdata_of = {2{sd[15:0]}};
         default: wdata_of = sd;
      endcase
   endfunction

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size_of(f3))
         2'd0:    extract = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
         2'd1:    extract = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
         default: extract = rd;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     load_data_q, load_data_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      off_q, off_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            bus_err_q, bus_err_d;

   logic            op_s;
   logic            misalign_s;
   logic [1:0]      size_s;
   logic [CW-1:0]   cnt_inc_s;

   // Decode of the incoming EX/MEM operation.
   always_comb begin
      op_s       = mem_rd_en | mem_wr_en;
      size_s     = size_of(funct3);
      misalign_s = ((size_s == 2'd1) && addr[0]) ||
                   ((size_s == 2'd2) && (addr[1:0] != 2'b00));
      // Saturating increment: the counter never wraps back to zero.
      cnt_inc_s  = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
   end

   // Next-state, registered-output and stall/exception logic of the FSM.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      load_data_d  = load_data_q;
      f3_d         = f3_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      bus_err_d    = 1'b0;
      mem_stall    = 1'b0;
      misalign_exc = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_s && misalign_s) begin
               misalign_exc = 1'b1;
            end else if (op_s) begin
               state_d   = REQ;
               req_d     = 1'b1;
               we_d      = mem_wr_en;
               be_d      = be_of(size_s, addr[1:0]);
               addr_d    = {addr[31:2], 2'b00};
               wdata_d   = wdata_of(size_s, store_data);
               f3_d      = funct3;
               off_d     = addr[1:0];
               cnt_d     = {CW{1'b0}};
               mem_stall = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            if (dmem_gnt) begin
               req_d   = 1'b0;
               cnt_d   = {CW{1'b0}};
               state_d = we_q ? DONE : WAIT_RSP;
            end else if (cnt_q == CNT_LAST) begin
               req_d       = 1'b0;
               bus_err_d   = 1'b1;
               load_data_d = 32'd0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         WAIT_RSP: begin
            mem_stall = 1'b1;
            if (dmem_rvalid) begin
               load_data_d = extract(f3_q, off_q, dmem_rdata);
               state_d     = DONE;
            end else if (cnt_q == CNT_LAST) begin
               bus_err_d   = 1'b1;
               load_data_d = 32'd0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         DONE: begin
            // Pipeline advances during this single unstalled cycle.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         load_data_q <= 32'd0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         cnt_q       <= {CW{1'b0}};
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_be    = be_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign load_data  = load_data_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        rst;
   logic        mem_rd_en, mem_wr_en;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata, load_data;
   logic        mem_stall, misalign_exc, bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(.XLEN(32), .TIMEOUT(16)) dut (
      .CLK(CLK), .rst(rst),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .funct3(funct3),
      .addr(addr), .store_data(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .load_data(load_data), .mem_stall(mem_stall),
      .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Load with gnt in the first REQ cycle and rvalid in the following cycle.
   // early_rv also pulses rvalid together with gnt, which must be ignored.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] eld, input bit early_rv);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      mem_rd_en = 1'b1; funct3 = f3; addr = a;
      #1;
      check_eq({tag, " idle_stall"}, mem_stall, 32'd1);
      check_eq({tag, " idle_misalign"}, misalign_exc, 32'd0);
      @(negedge CLK);
      check_eq({tag, " req"}, dmem_req, 32'd1);
      check_eq({tag, " we"}, dmem_we, 32'd0);
      check_eq({tag, " be"}, dmem_be, {28'd0, ebe});
      check_eq({tag, " addr"}, dmem_addr, wa);
      check_eq({tag, " req_stall"}, mem_stall, 32'd1);
      dmem_gnt = 1'b1;
      if (early_rv) begin
         dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
      end
      @(negedge CLK);
      check_eq({tag, " wait_req"}, dmem_req, 32'd0);
      check_eq({tag, " wait_stall"}, mem_stall, 32'd1);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
      @(negedge CLK);
      check_eq({tag, " load_data"}, load_data, eld);
      check_eq({tag, " done_stall"}, mem_stall, 32'd0);
      check_eq({tag, " done_buserr"}, bus_err, 32'd0);
      dmem_rvalid = 1'b0; mem_rd_en = 1'b0;
      @(negedge CLK);
      check_eq({tag, " after_stall"}, mem_stall, 32'd0);
      check_eq({tag, " after_ld"}, load_data, eld);
   endtask

   initial begin
      rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0; funct3 = 3'd0;
      addr = 32'd0; store_data = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      dmem_rdata = 32'd0;
      repeat (2) @(negedge CLK);
      rst = 1'b0;

      // Reset state
      check_eq("rst req", dmem_req, 32'd0);
      check_eq("rst we", dmem_we, 32'd0);
      check_eq("rst be", dmem_be, 32'd0);
      check_eq("rst addr", dmem_addr, 32'd0);
      check_eq("rst wdata", dmem_wdata, 32'd0);
      check_eq("rst load_data", load_data, 32'd0);
      check_eq("rst stall", mem_stall, 32'd0);
      check_eq("rst bus_err", bus_err, 32'd0);
      check_eq("rst misalign", misalign_exc, 32'd0);
      @(negedge CLK);

      // Word load and sub-word loads with sign/zero extension
      do_load("LW",  3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0);
      do_load("LB",  3'b000, 32'h103, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80, 1'b0);
      do_load("LBU", 3'b100, 32'h103, 32'h8011_2233, 4'b1000, 32'h0000_0080, 1'b0);
      do_load("LH",  3'b001, 32'h102, 32'h8011_2233, 4'b1100, 32'hFFFF_8011, 1'b1);
      do_load("LB1", 3'b000, 32'h101, 32'h8011_2233, 4'b0010, 32'h0000_0022, 1'b0);
      do_load("LHU", 3'b101, 32'h102, 32'h8011_2233, 4'b1100, 32'h0000_8011, 1'b0);

      // Byte store with grant held off for three cycles
      mem_wr_en = 1'b1; funct3 = 3'b000; addr = 32'h101; store_data = 32'h0000_00A5;
      #1;
      check_eq("SB idle_stall", mem_stall, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check_eq("SB req", dmem_req, 32'd1);
         check_eq("SB we", dmem_we, 32'd1);
         check_eq("SB addr", dmem_addr, 32'h100);
         check_eq("SB be", dmem_be, 32'h2);
         check_eq("SB wdata", dmem_wdata, 32'hA5A5_A5A5);
         check_eq("SB stall", mem_stall, 32'd1);
         if (i == 3) dmem_gnt = 1'b1;
      end
      @(negedge CLK);
      check_eq("SB done_req", dmem_req, 32'd0);
      check_eq("SB done_stall", mem_stall, 32'd0);
      check_eq("SB load_data", load_data, 32'h0000_8011);
      dmem_gnt = 1'b0; mem_wr_en = 1'b0;
      @(negedge CLK);

      // Misaligned half load and word store
      mem_rd_en = 1'b1; funct3 = 3'b001; addr = 32'h101;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("LH_mis exc", misalign_exc, 32'd1);
         check_eq("LH_mis stall", mem_stall, 32'd0);
         check_eq("LH_mis req", dmem_req, 32'd0);
         @(negedge CLK);
      end
      mem_rd_en = 1'b0; mem_wr_en = 1'b1; funct3 = 3'b010; addr = 32'h102;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("SW_mis exc", misalign_exc, 32'd1);
         check_eq("SW_mis stall", mem_stall, 32'd0);
         check_eq("SW_mis req", dmem_req, 32'd0);
         @(negedge CLK);
      end
      check_eq("mis load_data", load_data, 32'h0000_8011);
      mem_wr_en = 1'b0;
      #1;
      check_eq("nop exc", misalign_exc, 32'd0);
      @(negedge CLK);

      // Load never granted: timeout after 16 REQ cycles
      mem_rd_en = 1'b1; funct3 = 3'b010; addr = 32'h200;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         check_eq("TO req", dmem_req, 32'd1);
         check_eq("TO no_err", bus_err, 32'd0);
      end
      @(negedge CLK);
      check_eq("TO bus_err", bus_err, 32'd1);
      check_eq("TO req_drop", dmem_req, 32'd0);
      check_eq("TO load_data", load_data, 32'd0);
      check_eq("TO done_stall", mem_stall, 32'd0);
      mem_rd_en = 1'b0;
      @(negedge CLK);
      check_eq("TO pulse_end", bus_err, 32'd0);
      check_eq("TO idle_stall", mem_stall, 32'd0);

      // Reset during WAIT_RSP, late rvalid ignored
      do_load("LW2", 3'b010, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0);
      mem_rd_en = 1'b1; funct3 = 3'b010; addr = 32'h304;
      @(negedge CLK);
      dmem_gnt = 1'b1;
      @(negedge CLK);
      check_eq("RST wait_stall", mem_stall, 32'd1);
      dmem_gnt = 1'b0; rst = 1'b1; mem_rd_en = 1'b0;
      @(negedge CLK);
      rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
      #1;
      check_eq("RST req", dmem_req, 32'd0);
      check_eq("RST load_data", load_data, 32'd0);
      check_eq("RST stall", mem_stall, 32'd0);
      @(negedge CLK);
      dmem_rvalid = 1'b0;
      check_eq("RST late_rvalid", load_data, 32'd0);
      check_eq("RST late_req", dmem_req, 32'd0);
      check_eq("RST late_stall", mem_stall, 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
